wb_rr_arbiter2: RTL and testbench

WB_RR_ARBITER2 -- requirements
Module: wb_rr_arbiter2

---
 rtl/wb_rr_arbiter2.sv | 117 +++++++++++
 tb/tb_wb_rr_arbiter2.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter2.sv
// Two-master Wishbone round-robin arbiter with a slave-wait timeout.
// Ownership holds while the owner keeps cyc high; timeout ends a stalled access.
module wb_rr_arbiter2 #(
  parameter int TIMEOUT = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [63:0] m_adr_i,
  input  logic [63:0] m_dat_i,
  input  logic [7:0]  m_sel_i,
  input  logic [1:0]  m_we_i,
  input  logic [1:0]  m_cyc_i,
  input  logic [1:0]  m_stb_i,
  input  logic [5:0]  m_cti_i,
  input  logic [3:0]  m_bte_i,
  output logic [31:0] m_dat_o,
  output logic [1:0]  m_ack_o,
  output logic [1:0]  m_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic [2:0]  s_cti_o,
  output logic [1:0]  s_bte_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [CW-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic own, own0, sel;
  logic cyc_x, stb_x, we_x;
  logic tmo_inc, tmo_fire;

  assign own  = (state_q != IDLE);
  assign own0 = (state_q == OWN0);
  assign sel  = (state_q == OWN1);

  assign cyc_x = sel ? m_cyc_i[1] : m_cyc_i[0];
  assign stb_x = sel ? m_stb_i[1] : m_stb_i[0];
  assign we_x  = sel ? m_we_i[1]  : m_we_i[0];

  assign tmo_inc  = own & stb_x & ~s_ack_i & ~s_err_i;
  assign tmo_fire = tmo_inc && (tmo_cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (m_cyc_i[0] && m_cyc_i[1])
          state_d = last_q ? OWN0 : OWN1;
        else if (m_cyc_i[0])
          state_d = OWN0;
        else if (m_cyc_i[1])
          state_d = OWN1;
      end
      OWN0: if (!m_cyc_i[0])
        state_d = m_cyc_i[1] ? OWN1 : IDLE;
      OWN1: if (!m_cyc_i[1])
        state_d = m_cyc_i[0] ? OWN0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (state_d != state_q) begin
      if (state_d == OWN0) last_d = 1'b0;
      if (state_d == OWN1) last_d = 1'b1;
    end
  end

  // Counter restarts on any grant change so a new owner gets a full budget
  always_comb begin
    tmo_cnt_d = '0;
    if (tmo_inc && !tmo_fire && (state_d == state_q))
      tmo_cnt_d = tmo_cnt_q + CW'(1);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign s_adr_o = sel ? m_adr_i[63:32] : m_adr_i[31:0];
  assign s_dat_o = sel ? m_dat_i[63:32] : m_dat_i[31:0];
  assign s_sel_o = sel ? m_sel_i[7:4]   : m_sel_i[3:0];
  assign s_cti_o = sel ? m_cti_i[5:3]   : m_cti_i[2:0];
  assign s_bte_o = sel ? m_bte_i[3:2]   : m_bte_i[1:0];
  assign s_we_o  = own & we_x;
  assign s_cyc_o = own & cyc_x;
  assign s_stb_o = own & stb_x & ~tmo_fire;

  assign m_dat_o = s_dat_i;
  assign m_ack_o = {sel & s_ack_i, own0 & s_ack_i};
  assign m_err_o = {sel & (s_err_i | tmo_fire),
                    own0 & (s_err_i | tmo_fire)};
  assign grant_o = {sel, own0};

endmodule

// File: tb/tb_wb_rr_arbiter2.sv
// Directed bench for wb_rr_arbiter2: arbitration, bursts,
// timeout, ack/timeout collision and mid-burst reset.
module tb_wb_rr_arbiter2;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] m_adr, m_dat;
  logic [7:0]  m_sel;
  logic [1:0]  m_we, m_cyc, m_stb;
  logic [5:0]  m_cti;
  logic [3:0]  m_bte;
  logic [31:0] m_dat_o;
  logic [1:0]  m_ack, m_err;
  logic [31:0] s_adr, s_dat_o;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic [31:0] s_dat;
  logic        s_ack, s_err;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;
  int pulses;

  always #5 clk = ~clk;

  wb_rr_arbiter2 #(.TIMEOUT(16)) dut (
    .wb_clk_i(clk),   .wb_rst_i(rst),
    .m_adr_i(m_adr),  .m_dat_i(m_dat),
    .m_sel_i(m_sel),  .m_we_i(m_we),
    .m_cyc_i(m_cyc),  .m_stb_i(m_stb),
    .m_cti_i(m_cti),  .m_bte_i(m_bte),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack),
    .m_err_o(m_err),  .s_adr_o(s_adr),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel),
    .s_we_o(s_we),    .s_cyc_o(s_cyc),
    .s_stb_o(s_stb),  .s_cti_o(s_cti),
    .s_bte_o(s_bte),  .s_dat_i(s_dat),
    .s_ack_i(s_ack),  .s_err_i(s_err),
    .grant_o(grant)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    m_adr = 64'h1111_2222_AAAA_0000;
    m_dat = 64'hDEAD_0001_BEEF_0000;
    m_sel = 8'hC3;
    m_we  = 2'b11;
    m_cyc = 2'b00;
    m_stb = 2'b00;
    m_cti = 6'b000_000;
    m_bte = 4'b10_01;
    s_dat = 32'h5A5A_1234;
    s_ack = 1'b1;
    s_err = 1'b1;

    // reset state, with slave ack/err high to prove gating
    tick();
    tick();
    chk("rst_grant", grant, 2'b00);
    chk("rst_cyc", s_cyc, 1'b0);
    chk("rst_ack", m_ack, 2'b00);
    chk("rst_err", m_err, 2'b00);
    chk("idle_we", s_we, 1'b0);
    chk("idle_adr", s_adr, 32'hAAAA_0000);
    chk("dat_bcast", m_dat_o, 32'h5A5A_1234);

    // contention out of reset: m0 first
    rst   = 1'b0;
    s_err = 1'b0;
    m_cyc = 2'b11;
    tick();
    chk("c1_grant", grant, 2'b01);
    chk("c1_cyc", s_cyc, 1'b1);
    chk("c1_adr", s_adr, 32'hAAAA_0000);
    chk("c1_sel", s_sel, 4'h3);
    chk("c1_ack", m_ack, 2'b01);
    s_ack = 1'b0;
    m_cyc = 2'b10;
    settle();
    chk("ho_cyc_low", s_cyc, 1'b0);
    chk("ho_grant_hold", grant, 2'b01);
    tick();
    chk("c2_grant", grant, 2'b10);
    chk("c2_adr", s_adr, 32'h1111_2222);
    chk("c2_dat", s_dat_o, 32'hDEAD_0001);
    chk("c2_bte", s_bte, 2'b10);
    chk("c2_we", s_we, 1'b1);
    m_cyc = 2'b00;
    tick();
    chk("c3_idle", grant, 2'b00);
    chk("c3_cyc", s_cyc, 1'b0);
    m_cyc = 2'b11;
    tick();
    chk("c4_alt_grant", grant, 2'b01);

    // m1 burst of 8 beats while m0 keeps requesting
    m_cyc = 2'b10;
    tick();
    chk("b_grant", grant, 2'b10);
    m_cyc = 2'b11;
    m_stb = 2'b10;
    s_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      m_cti = (i == 7) ? 6'b111_000 : 6'b010_000;
      settle();
      chk($sformatf("b%0d_grant", i), grant, 2'b10);
      chk($sformatf("b%0d_ack", i), m_ack, 2'b10);
      chk($sformatf("b%0d_cti", i), s_cti,
          (i == 7) ? 3'b111 : 3'b010);
      tick();
    end
    m_cyc = 2'b01;
    m_stb = 2'b00;
    m_cti = 6'b000_000;
    s_ack = 1'b0;
    settle();
    chk("b_end_cyc", s_cyc, 1'b0);
    chk("b_end_ack", m_ack, 2'b00);
    tick();
    chk("b_ho_grant", grant, 2'b01);

    // m0 strobing with a silent slave: err every 16 waits
    m_stb  = 2'b01;
    pulses = 0;
    for (int k = 1; k <= 32; k++) begin
      settle();
      if (m_err[0]) pulses++;
      chk($sformatf("t%0d_err", k), m_err,
          (k == 16 || k == 32) ? 2'b01 : 2'b00);
      chk($sformatf("t%0d_stb", k), s_stb,
          (k == 16 || k == 32) ? 1'b0 : 1'b1);
      tick();
    end
    chk("t_pulses", pulses, 2);
    chk("t_keep_grant", grant, 2'b01);

    // ack lands on the cycle a timeout would fire
    for (int k = 1; k <= 16; k++) begin
      s_ack = (k == 16);
      settle();
      if (k == 16) begin
        chk("a_ack", m_ack, 2'b01);
        chk("a_err", m_err, 2'b00);
        chk("a_stb", s_stb, 1'b1);
      end
      tick();
    end
    s_ack = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      settle();
      chk($sformatf("r%0d_err", k), m_err,
          (k == 16) ? 2'b01 : 2'b00);
      tick();
    end

    // ack and err together pass through
    s_ack = 1'b1;
    s_err = 1'b1;
    settle();
    chk("ae_ack", m_ack, 2'b01);
    chk("ae_err", m_err, 2'b01);
    s_ack = 1'b0;
    s_err = 1'b0;
    m_stb = 2'b00;

    // reset mid-burst while m1 owns
    m_cyc = 2'b10;
    tick();
    chk("m_grant", grant, 2'b10);
    m_stb = 2'b10;
    m_cti = 6'b010_000;
    tick();
    tick();
    m_cyc = 2'b11;
    rst   = 1'b1;
    s_ack = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_grant", grant, 2'b00);
    chk("mr_cyc", s_cyc, 1'b0);
    chk("mr_ack", m_ack, 2'b00);
    tick();
    chk("mr_m0_grant", grant, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
